// File: rtl/p_alu_if.sv
// Host-side bundle for the p_alu accumulator.
interface p_alu_if #(
  parameter int DATA_W = 8
);
  // Handshake: i_p_alu_start is a level and only its rising edge seen while the
  // ALU is idle starts an operation; the keycode and operand are sampled on that
  // edge cycle. o_p_alu_busy covers the iterative cycles of * and /, and
  // o_p_alu_done pulses for exactly one cycle as the result and flag become valid.
  logic              i_p_alu_start;
  logic [3:0]        i_p_alu_op_keycode;
  logic [DATA_W:0]   i_p_alu_operand;
  logic [DATA_W:0]   o_p_alu_result;
  logic              o_p_alu_overflow_flag;
  logic              o_p_alu_busy;
  logic              o_p_alu_done;
  logic [1:0]        o_p_alu_dbg_state;

  modport master (
    output i_p_alu_start, i_p_alu_op_keycode, i_p_alu_operand,
    input  o_p_alu_result, o_p_alu_overflow_flag, o_p_alu_busy, o_p_alu_done,
    input  o_p_alu_dbg_state
  );

  modport slave (
    input  i_p_alu_start, i_p_alu_op_keycode, i_p_alu_operand,
    output o_p_alu_result, o_p_alu_overflow_flag, o_p_alu_busy, o_p_alu_done,
    output o_p_alu_dbg_state
  );
endinterface

// File: rtl/p_alu.sv
// Sign-magnitude accumulator ALU with iterative shift-add multiply and restoring divide.
// Define P_ALU_DIV_EN to build the divider; without it '/' reports invalid in one cycle.
module p_alu #(
  parameter int DATA_W         = 8,
  parameter int MUL_DIV_CYCLES = DATA_W
) (
  input  logic   i_sys_clock,
  input  logic   i_sys_reset,
  p_alu_if.slave alu
);
  localparam int CNT_W = $clog2(MUL_DIV_CYCLES + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_CLR = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                start_prev_q, start_prev_d;
  logic                b_sign_q, b_sign_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W:0]     result_q, result_d;
  logic                flag_q, flag_d;
`ifdef P_ALU_DIV_EN
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W:0]     div_shifted;
  logic                div_borrow;
  logic [DATA_W-1:0]   rem_step, quo_step;
`endif

  logic                start_in;
  logic [3:0]          op_in;
  logic                a_sign, b_sign_in;
  logic [DATA_W-1:0]   a_mag, b_mag_in;
  logic                accept, is_multi, last_iter;

  logic [DATA_W+1:0]   sa, sb, sum, abs_sum;
  logic [DATA_W-1:0]   sh_mag;
  logic [DATA_W:0]     sc_res;
  logic                sc_ovf, sc_upd;

  logic [DATA_W:0]     mul_hi;
  logic [2*DATA_W-1:0] prod_step;
  logic [DATA_W-1:0]   fin_mag;
  logic [DATA_W:0]     fin_res;
  logic                fin_ovf;

  assign start_in  = alu.i_p_alu_start;
  assign op_in     = alu.i_p_alu_op_keycode;
  assign b_sign_in = alu.i_p_alu_operand[DATA_W];
  assign b_mag_in  = alu.i_p_alu_operand[DATA_W-1:0];
  assign a_sign    = result_q[DATA_W];
  assign a_mag     = result_q[DATA_W-1:0];

  assign accept    = (state_q == ST_IDLE) && start_in && !start_prev_q;
  assign last_iter = (cnt_q == CNT_W'(MUL_DIV_CYCLES - 1));

  // Once the flag is set every op but clear is a one-cycle no-op.
  always_comb begin
    is_multi = 1'b0;
    if (!flag_q) begin
      if (op_in == OP_MUL) is_multi = 1'b1;
`ifdef P_ALU_DIV_EN
      if (op_in == OP_DIV) is_multi = 1'b1;
`endif
    end
  end

  // FSM: state register
  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_multi ? ST_EXEC : ST_DONE;
      ST_EXEC: if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    alu.o_p_alu_busy      = (state_q == ST_EXEC);
    alu.o_p_alu_done      = (state_q == ST_DONE);
    alu.o_p_alu_dbg_state = state_q;
  end

  assign alu.o_p_alu_result        = result_q;
  assign alu.o_p_alu_overflow_flag = flag_q;

  // Single-cycle ops; add/sub widen by two bits so |sum| up to 2*(2^W-1) is exact.
  always_comb begin
    sa      = a_sign    ? -{2'b00, a_mag}    : {2'b00, a_mag};
    sb      = b_sign_in ? -{2'b00, b_mag_in} : {2'b00, b_mag_in};
    sum     = (op_in == OP_SUB) ? (sa - sb) : (sa + sb);
    abs_sum = sum[DATA_W+1] ? -sum : sum;
    sh_mag  = (op_in == OP_SHL) ? (a_mag << b_mag_in) : (a_mag >> b_mag_in);
    sc_res  = result_q;
    sc_ovf  = 1'b0;
    sc_upd  = 1'b0;
    case (op_in)
      OP_ADD, OP_SUB: begin
        if (|abs_sum[DATA_W+1:DATA_W]) begin
          sc_ovf = 1'b1;
        end else begin
          sc_upd = 1'b1;
          sc_res = {sum[DATA_W+1] & (|abs_sum[DATA_W-1:0]), abs_sum[DATA_W-1:0]};
        end
      end
      OP_AND: begin sc_upd = 1'b1; sc_res = {1'b0, a_mag & b_mag_in}; end
      OP_OR:  begin sc_upd = 1'b1; sc_res = {1'b0, a_mag | b_mag_in}; end
      OP_XOR: begin sc_upd = 1'b1; sc_res = {1'b0, a_mag ^ b_mag_in}; end
      OP_SHR, OP_SHL: begin
        if (b_sign_in) begin
          sc_ovf = 1'b1;
        end else begin
          sc_upd = 1'b1;
          sc_res = {a_sign & (|sh_mag), sh_mag};
        end
      end
      OP_DIV:  sc_ovf = 1'b1;
      default: sc_upd = 1'b0;
    endcase
  end

  // One shift-add step: add multiplicand into the high half when the low bit is set, shift right.
  always_comb begin
    mul_hi    = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, a_mag} : '0);
    prod_step = {mul_hi, prod_q[DATA_W-1:1]};
  end

`ifdef P_ALU_DIV_EN
  // One restoring-divide step; the remainder always stays below the divisor.
  always_comb begin
    div_shifted = {rem_q, quo_q[DATA_W-1]};
    div_borrow  = (div_shifted < {1'b0, dvsr_q});
    rem_step    = div_borrow ? div_shifted[DATA_W-1:0] : (div_shifted[DATA_W-1:0] - dvsr_q);
    quo_step    = {quo_q[DATA_W-2:0], ~div_borrow};
  end
`endif

  always_comb begin
    fin_mag = prod_step[DATA_W-1:0];
    fin_ovf = |prod_step[2*DATA_W-1:DATA_W];
`ifdef P_ALU_DIV_EN
    if (op_q == OP_DIV) begin
      fin_mag = quo_step;
      fin_ovf = (dvsr_q == '0);
    end
`endif
    fin_res = {(a_sign ^ b_sign_q) & (|fin_mag), fin_mag};
  end

  always_comb begin
    start_prev_d = start_in;
    b_sign_d     = b_sign_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    result_d     = result_q;
    flag_d       = flag_q;
`ifdef P_ALU_DIV_EN
    op_d         = op_q;
    dvsr_d       = dvsr_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
`endif
    if (accept) begin
      b_sign_d = b_sign_in;
      cnt_d    = '0;
      prod_d   = {{DATA_W{1'b0}}, b_mag_in};
`ifdef P_ALU_DIV_EN
      op_d     = op_in;
      dvsr_d   = b_mag_in;
      rem_d    = '0;
      quo_d    = a_mag;
`endif
      if (op_in == OP_CLR) begin
        result_d = '0;
        flag_d   = 1'b0;
      end else if (!flag_q && !is_multi) begin
        if (sc_ovf)      flag_d   = 1'b1;
        else if (sc_upd) result_d = sc_res;
      end
    end else if (state_q == ST_EXEC) begin
      cnt_d  = cnt_q + CNT_W'(1);
      prod_d = prod_step;
`ifdef P_ALU_DIV_EN
      rem_d  = rem_step;
      quo_d  = quo_step;
`endif
      if (last_iter) begin
        if (fin_ovf) flag_d   = 1'b1;
        else         result_d = fin_res;
      end
    end
  end

  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      start_prev_q <= 1'b0;
      b_sign_q     <= 1'b0;
      cnt_q        <= '0;
      prod_q       <= '0;
      result_q     <= '0;
      flag_q       <= 1'b0;
`ifdef P_ALU_DIV_EN
      op_q         <= '0;
      dvsr_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
`endif
    end else begin
      start_prev_q <= start_prev_d;
      b_sign_q     <= b_sign_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      result_q     <= result_d;
      flag_q       <= flag_d;
`ifdef P_ALU_DIV_EN
      op_q         <= op_d;
      dvsr_q       <= dvsr_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
`endif
    end
  end
endmodule

// File: doc/p_alu.md
P_ALU -- requirements
Module: p_alu

Interface
REQ-001 Parameter DATA_W, default 8, magnitude width; all data ports are DATA_W+1 bits sign-magnitude (bit DATA_W = sign).
REQ-002 Parameter MUL_DIV_CYCLES, default DATA_W, iteration count of the shift-add multiplier and restoring divider (SHALL equal DATA_W).
REQ-003 i_sys_clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_sys_reset  input  1  synchronous, active-high reset.
REQ-005 i_p_alu_start  input  1  level; rising edge requests one operation.
REQ-006 i_p_alu_op_keycode  input  4  0000 +, 0001 -, 0010 *, 0011 /, 0101 &, 0110 |, 0111 ^, 1000 >>, 1001 <<, 1111 clear; others no-op.
REQ-007 i_p_alu_operand  input  DATA_W+1  operand B, sign-magnitude.
REQ-008 o_p_alu_result  output  DATA_W+1  accumulator A, registered.
REQ-009 o_p_alu_overflow_flag  output  1  sticky overflow/invalid, registered.
REQ-010 o_p_alu_busy  output  1  high while a multi-cycle op executes.
REQ-011 o_p_alu_done  output  1  one-cycle pulse when an op completes.

Function
REQ-012 FSM states IDLE, EXEC, DONE; IDLE->DONE for single-cycle ops, IDLE->EXEC for * and /, EXEC->DONE after MUL_DIV_CYCLES cycles, DONE->IDLE unconditionally.
REQ-013 Start edge detected by registered previous start; op keycode and operand captured on the edge cycle N.
REQ-014 Single-cycle ops: result/flag updated and done=1 in cycle N+1.
REQ-015 * and /: busy=1 cycles N+1..N+MUL_DIV_CYCLES, result/flag updated and done=1 in cycle N+MUL_DIV_CYCLES+1.
REQ-016 Start edges while busy or done are ignored, not queued; operand/op changes during EXEC do not affect the running op.
REQ-017 + and -: signed add on DATA_W+2-bit internal value; |result| > 2^DATA_W-1 -> overflow.
REQ-018 *: magnitude product, sign = XOR of signs; product > 2^DATA_W-1 -> overflow.
REQ-019 /: quotient truncated toward zero, sign = XOR; divisor magnitude 0 -> overflow.
REQ-020 &, |, ^: applied to magnitudes; result sign 0.
REQ-021 >>, <<: logical shift of A magnitude by B magnitude, A sign kept; B negative -> overflow; count >= DATA_W -> magnitude 0.
REQ-022 Any zero-magnitude result SHALL have sign 0 (no negative zero).
REQ-023 On overflow: result unchanged, flag set; flag stays set until clear op or reset.
REQ-024 While flag set, all ops except clear complete with done pulse and no state change.
REQ-025 Clear (1111): result 0, flag 0, single-cycle.
REQ-026 Undefined keycodes: single-cycle, done pulse, no state change.

Reset
REQ-027 Reset: result 0, flag 0, busy 0, done 0, FSM IDLE, previous-start register 0.
REQ-028 Reset during EXEC aborts op; next cycle outputs as REQ-027, no done pulse.
REQ-029 Reset has priority over a simultaneous start edge.

Configuration
REQ-030 Macro P_ALU_DIV_EN defined: divider built, / per REQ-019.
REQ-031 P_ALU_DIV_EN undefined: no divider logic; / completes single-cycle, flag set, result unchanged, busy never asserted.

Verification (DATA_W=8)
REQ-032 Reset; + with +100 -> result 100, flag 0, done at N+1, busy 0.
REQ-033 A=100; * with -2 -> busy cycles N+1..N+8, done N+9, result -200 (1_1100_1000); then * with 3 -> flag 1, result -200.
REQ-034 A=-5; + with +5 -> result 9'b0_0000_0000; / with 0 (DIV_EN) -> flag 1; + with 1 -> done, no change; clear -> 0, flag 0.
REQ-035 A=3; << with 9 -> 0; A=3; << with -1 -> flag 1, result 3.
REQ-036 Start * then second start edge at N+3 -> ignored, single done; reset at N+4 -> next cycle result 0, busy 0, no done.
